// File: rtl/fpd_link_rx_decoder.sv
// FPD-Link RGB666 receiver: recovers 7-bit word alignment from the clock lane,
// decodes pixels and control bits, and measures active width / line count.
module fpd_link_rx_decoder #(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic        pllInClock,
  input  logic        reset,
  input  logic [3:0]  lvdsIn,
  output logic        pixelValid,
  output logic [5:0]  red,
  output logic [5:0]  green,
  output logic [5:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        locked,
  output logic [10:0] activeWidth,
  output logic [10:0] lineCount
);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [6:0]  CLK_PATTERN = 7'b1100011;
  localparam logic [10:0] SAT_MAX     = 11'd2047;
  localparam logic [7:0]  LOCK_N      = 8'(LOCK_COUNT);
  localparam logic [7:0]  UNLOCK_N    = 8'(UNLOCK_COUNT);

  state_t      r_state;
  logic [5:0]  r_hist [0:3];
  logic [2:0]  r_phase;
  logic        r_hold;
  logic [7:0]  r_good;
  logic [7:0]  r_bad;
  logic [10:0] r_width;
  logic [10:0] r_lines;
  logic        r_prev_de;
  logic        r_prev_vs;

  logic [6:0]  w_word [0:3];
  logic        w_sample;
  logic        w_match;
  logic        w_slip;
  logic        w_de;
  logic        w_vs;
  logic [10:0] w_width_inc;
  logic [10:0] w_lines_next;

  // The word includes the bit arriving on this edge, so it is complete at the sample edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_word[i] = {r_hist[i], lvdsIn[i]};
    end
  end

  // The hold cycle after a slip sits at phase 6 but is not a sample point.
  assign w_sample     = (r_phase == 3'd6) && !r_hold;
  assign w_match      = (w_word[0] == CLK_PATTERN);
  assign w_slip       = w_sample && !w_match && (r_state != LOCKED);
  assign w_de         = w_word[3][6];
  assign w_vs         = w_word[3][5];
  assign w_width_inc  = (r_width == SAT_MAX) ? r_width : r_width + 11'd1;
  assign w_lines_next = (w_de && !r_prev_de && (r_lines != SAT_MAX)) ? r_lines + 11'd1 : r_lines;

  always_ff @(posedge pllInClock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_hist[i] <= 6'd0;
      end
      r_state     <= SEARCH;
      r_phase     <= 3'd0;
      r_hold      <= 1'b0;
      r_good      <= 8'd0;
      r_bad       <= 8'd0;
      r_width     <= 11'd0;
      r_lines     <= 11'd0;
      r_prev_de   <= 1'b0;
      r_prev_vs   <= 1'b0;
      pixelValid  <= 1'b0;
      red         <= 6'd0;
      green       <= 6'd0;
      blue        <= 6'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      locked      <= 1'b0;
      activeWidth <= 11'd0;
      lineCount   <= 11'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_hist[i] <= w_word[i][5:0];
      end
      pixelValid <= 1'b0;
      locked     <= (r_state == LOCKED);
      if (w_slip) begin
        r_hold <= 1'b1;
      end else begin
        r_hold  <= 1'b0;
        r_phase <= (r_phase == 3'd6) ? 3'd0 : r_phase + 3'd1;
      end
      if (w_sample) begin
        case (r_state)
          SEARCH: begin
            if (w_match) begin
              r_state <= VERIFY;
              r_good  <= 8'd1;
            end
          end
          VERIFY: begin
            if (!w_match) begin
              r_state <= SEARCH;
            end else begin
              r_good <= r_good + 8'd1;
              if (r_good + 8'd1 == LOCK_N) begin
                r_state <= LOCKED;
                r_bad   <= 8'd0;
              end
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_bad      <= 8'd0;
              pixelValid <= 1'b1;
              red        <= w_word[1][5:0];
              green      <= {w_word[2][4:0], w_word[1][6]};
              blue       <= {w_word[3][3:0], w_word[2][6:5]};
              hsync      <= w_word[3][4];
              vsync      <= w_vs;
              de         <= w_de;
              r_prev_de  <= w_de;
              r_prev_vs  <= w_vs;
              if (w_de) begin
                r_width <= w_width_inc;
              end else if (r_prev_de) begin
                activeWidth <= r_width;
                r_width     <= 11'd0;
              end
              // A vsync rise latches the count including a line that starts on this pixel.
              if (w_vs && !r_prev_vs) begin
                lineCount <= w_lines_next;
                r_lines   <= 11'd0;
              end else begin
                r_lines <= w_lines_next;
              end
            end else if (r_bad + 8'd1 == UNLOCK_N) begin
              r_state   <= SEARCH;
              r_bad     <= 8'd0;
              r_width   <= 11'd0;
              r_lines   <= 11'd0;
              r_prev_de <= 1'b0;
              r_prev_vs <= 1'b0;
            end else begin
              r_bad <= r_bad + 8'd1;
            end
          end
          default: begin
            r_state <= SEARCH;
          end
        endcase
      end
    end
  end

endmodule
